// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter for up to N requesters with a one-hot registered grant.
// A winner is picked by binary index from a rotating priority pointer, then
// decoded to a one-hot grant. The grant is held until the owner signals done,
// drops its request, or the optional hold timeout expires. One idle cycle
// always separates consecutive grants.
module rr_onehot_arbiter #(
  parameter int unsigned N        = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned MAX_HOLD = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N-1:0]     i_req,
  input  logic             i_done,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_grant_valid,
  output logic             o_timeout
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  // Last counter value a grant may reach; MAX_HOLD == 0 disables expiry.
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
  localparam logic [N-1:0]     OneHot0  = N'(1);

  state_e           r_state_q, w_state_d;
  logic [N-1:0]     r_grant_q, w_grant_d;
  logic [IDX_W-1:0] r_idx_q, w_idx_d;
  logic             r_valid_q, w_valid_d;
  logic             r_timeout_q, w_timeout_d;
  logic [IDX_W-1:0] r_ptr_q, w_ptr_d;
  logic [CNT_W-1:0] r_cnt_q, w_cnt_d;

  logic             w_found;
  logic [IDX_W-1:0] w_winner;
  logic [N-1:0]     w_onehot;
  logic             w_owner_req;
  logic             w_expire;
  logic             w_release;

  // Rotating priority scan: first set request at or after the pointer, wrapping.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand     = '0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = r_ptr_q + IDX_W'(i);
      if (!w_found && i_req[cand]) begin
        w_found  = 1'b1;
        w_winner = cand;
      end
    end
  end

  // Index-to-one-hot decode of the winner.
  always_comb begin
    w_onehot = OneHot0 << w_winner;
  end

  // Release conditions for the current owner.
  always_comb begin
    w_owner_req = i_req[r_idx_q];
    w_expire    = (MAX_HOLD != 0) && (r_cnt_q == HoldLast);
    w_release   = i_done || !w_owner_req || w_expire;
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_d   = r_state_q;
    w_grant_d   = r_grant_q;
    w_idx_d     = r_idx_q;
    w_valid_d   = r_valid_q;
    w_timeout_d = 1'b0;
    w_ptr_d     = r_ptr_q;
    w_cnt_d     = r_cnt_q;
    unique case (r_state_q)
      StIdle: begin
        w_grant_d = '0;
        w_valid_d = 1'b0;
        if (w_found) begin
          w_grant_d = w_onehot;
          w_idx_d   = w_winner;
          w_valid_d = 1'b1;
          w_cnt_d   = '0;
          w_state_d = StGrant;
        end
      end
      StGrant: begin
        if (w_release) begin
          w_grant_d   = '0;
          w_valid_d   = 1'b0;
          w_ptr_d     = r_idx_q + IDX_W'(1);
          // Timeout only when expiry is the sole reason for release.
          w_timeout_d = w_expire && !i_done && w_owner_req;
          w_state_d   = StIdle;
        end else if (r_cnt_q != CntMax) begin
          w_cnt_d = r_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
        w_grant_d = '0;
        w_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state_q   <= StIdle;
      r_grant_q   <= '0;
      r_idx_q     <= '0;
      r_valid_q   <= 1'b0;
      r_timeout_q <= 1'b0;
      r_ptr_q     <= '0;
      r_cnt_q     <= '0;
    end else begin
      r_state_q   <= w_state_d;
      r_grant_q   <= w_grant_d;
      r_idx_q     <= w_idx_d;
      r_valid_q   <= w_valid_d;
      r_timeout_q <= w_timeout_d;
      r_ptr_q     <= w_ptr_d;
      r_cnt_q     <= w_cnt_d;
    end
  end

  assign o_grant       = r_grant_q;
  assign o_grant_idx   = r_idx_q;
  assign o_grant_valid = r_valid_q;
  assign o_timeout     = r_timeout_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter: a default instance and a short-timeout
// instance (MAX_HOLD=4) share clock and reset.
module tb_rr_onehot_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] req, t_req;
  logic        done, t_done;
  logic [15:0] grant, t_grant;
  logic [3:0]  grant_idx, t_grant_idx;
  logic        grant_valid, t_grant_valid;
  logic        timeout, t_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  rr_onehot_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_done       (done),
    .o_grant      (grant),
    .o_grant_idx  (grant_idx),
    .o_grant_valid(grant_valid),
    .o_timeout    (timeout)
  );

  rr_onehot_arbiter #(.MAX_HOLD(4)) dut_t (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (t_req),
    .i_done       (t_done),
    .o_grant      (t_grant),
    .o_grant_idx  (t_grant_idx),
    .o_grant_valid(t_grant_valid),
    .o_timeout    (t_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    req    = '0;
    done   = 1'b0;
    t_req  = '0;
    t_done = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({grant, grant_idx, grant_valid, timeout} !== 22'd0)
      $display("FAIL reset_state: got g=%h i=%0d v=%b t=%b want all zero",
               grant, grant_idx, grant_valid, timeout);
    else n_pass++;
    n_checks++;
    if ({t_grant, t_grant_idx, t_grant_valid, t_timeout} !== 22'd0)
      $display("FAIL reset_state_t: got g=%h i=%0d v=%b t=%b want all zero",
               t_grant, t_grant_idx, t_grant_valid, t_timeout);
    else n_pass++;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if ({grant, grant_valid, timeout} !== 18'd0)
        $display("FAIL idle_noreq cyc%0d: got g=%h v=%b t=%b want 0", c, grant, grant_valid,
                 timeout);
      else n_pass++;
    end
    // Reset asserted while a grant is held clears outputs without waiting for an edge.
    req = 16'h0001;
    tick();
    n_checks++;
    if ({grant, grant_idx, grant_valid} !== {16'h0001, 4'd0, 1'b1})
      $display("FAIL pre_reset_grant: got g=%h i=%0d v=%b want 0001/0/1", grant, grant_idx,
               grant_valid);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({grant, grant_idx, grant_valid, timeout} !== 22'd0)
      $display("FAIL midgrant_reset: got g=%h i=%0d v=%b t=%b want all zero",
               grant, grant_idx, grant_valid, timeout);
    else n_pass++;
    req = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    apply_reset();
    req = 16'h0014;
    tick();
    n_checks++;
    if ({grant, grant_idx, grant_valid} !== {16'h0004, 4'd2, 1'b1})
      $display("FAIL basic_first: got g=%h i=%0d v=%b want 0004/2/1", grant, grant_idx,
               grant_valid);
    else n_pass++;
    done = 1'b1;
    tick();
    n_checks++;
    if ({grant, grant_valid, timeout} !== 18'd0)
      $display("FAIL basic_idle1: got g=%h v=%b t=%b want 0/0/0", grant, grant_valid, timeout);
    else n_pass++;
    done = 1'b0;
    tick();
    n_checks++;
    if ({grant, grant_idx, grant_valid} !== {16'h0010, 4'd4, 1'b1})
      $display("FAIL basic_second: got g=%h i=%0d v=%b want 0010/4/1", grant, grant_idx,
               grant_valid);
    else n_pass++;
    done = 1'b1;
    tick();
    n_checks++;
    if ({grant, grant_valid} !== 17'd0)
      $display("FAIL basic_idle2: got g=%h v=%b want 0/0", grant, grant_valid);
    else n_pass++;
    done = 1'b0;
    tick();
    n_checks++;
    if ({grant, grant_idx, grant_valid} !== {16'h0004, 4'd2, 1'b1})
      $display("FAIL basic_wrap: got g=%h i=%0d v=%b want 0004/2/1", grant, grant_idx,
               grant_valid);
    else n_pass++;
    req = '0;
    tick();
  endtask

  task automatic test_fairness();
    logic [15:0] exp_g;
    apply_reset();
    req = 16'hFFFF;
    for (int k = 0; k < 17; k++) begin
      exp_g = 16'h0001 << (k % 16);
      tick();
      n_checks++;
      if ({grant, grant_idx, grant_valid} !== {exp_g, 4'(k % 16), 1'b1})
        $display("FAIL fair_grant k=%0d: got g=%h i=%0d v=%b want %h/%0d/1", k, grant, grant_idx,
                 grant_valid, exp_g, k % 16);
      else n_pass++;
      tick();
      n_checks++;
      if (grant !== exp_g)
        $display("FAIL fair_hold k=%0d: got g=%h want %h", k, grant, exp_g);
      else n_pass++;
      done = 1'b1;
      tick();
      done = 1'b0;
      n_checks++;
      if ({grant, grant_valid} !== 17'd0)
        $display("FAIL fair_idle k=%0d: got g=%h v=%b want 0/0", k, grant, grant_valid);
      else n_pass++;
    end
    req = '0;
    tick();
  endtask

  task automatic test_timeout();
    apply_reset();
    t_req = 16'h0080;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if ({t_grant, t_grant_idx, t_grant_valid, t_timeout} !== {16'h0080, 4'd7, 1'b1, 1'b0})
        $display("FAIL to_hold cyc%0d: got g=%h i=%0d v=%b t=%b want 0080/7/1/0", c, t_grant,
                 t_grant_idx, t_grant_valid, t_timeout);
      else n_pass++;
    end
    tick();
    n_checks++;
    if ({t_grant, t_grant_valid, t_timeout} !== {16'h0000, 1'b0, 1'b1})
      $display("FAIL to_expire: got g=%h v=%b t=%b want 0000/0/1", t_grant, t_grant_valid,
               t_timeout);
    else n_pass++;
    tick();
    n_checks++;
    if ({t_grant, t_grant_valid, t_timeout} !== {16'h0080, 1'b1, 1'b0})
      $display("FAIL to_regrant: got g=%h v=%b t=%b want 0080/1/0", t_grant, t_grant_valid,
               t_timeout);
    else n_pass++;
  endtask

  // Continues from the regrant of test_timeout: done lands on the expiry cycle.
  task automatic test_timeout_done();
    for (int c = 0; c < 3; c++) tick();
    n_checks++;
    if (t_grant !== 16'h0080)
      $display("FAIL tod_hold: got g=%h want 0080", t_grant);
    else n_pass++;
    t_done = 1'b1;
    tick();
    t_done = 1'b0;
    n_checks++;
    if ({t_grant, t_grant_valid, t_timeout} !== 18'd0)
      $display("FAIL tod_release: got g=%h v=%b t=%b want 0000/0/0", t_grant, t_grant_valid,
               t_timeout);
    else n_pass++;
    t_req = '0;
    tick();
  endtask

  task automatic test_req_drop();
    apply_reset();
    req = 16'h0208;
    tick();
    n_checks++;
    if ({grant, grant_idx, grant_valid} !== {16'h0008, 4'd3, 1'b1})
      $display("FAIL drop_grant3: got g=%h i=%0d v=%b want 0008/3/1", grant, grant_idx,
               grant_valid);
    else n_pass++;
    req = 16'h0200;
    tick();
    n_checks++;
    if ({grant, grant_valid, timeout} !== 18'd0)
      $display("FAIL drop_release: got g=%h v=%b t=%b want 0/0/0", grant, grant_valid, timeout);
    else n_pass++;
    tick();
    n_checks++;
    if ({grant, grant_idx, grant_valid} !== {16'h0200, 4'd9, 1'b1})
      $display("FAIL drop_next: got g=%h i=%0d v=%b want 0200/9/1", grant, grant_idx,
               grant_valid);
    else n_pass++;
    req = '0;
    tick();
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    done   = 1'b0;
    t_req  = '0;
    t_done = 1'b0;
    test_reset();
    test_basic();
    test_fairness();
    test_timeout();
    test_timeout_done();
    test_req_drop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter that shares one resource among up to 16 requesters.
- Selects a winner by binary index, then decodes that index to a one-hot grant vector (index-to-one-hot, 1 << idx).
- Holds the grant until the owner releases it or a hold timeout expires.
- Sits between requester blocks and the shared datapath; grant_idx drives muxes and grant drives per-requester enables.

Parameters:
- N, 16, number of requesters; power of two, 2..16.
- IDX_W, 4, index width; must equal log2(N).
- MAX_HOLD, 255, max cycles a grant may be held; 0 disables the timeout.
- CNT_W, 8, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request per requester; level-sensitive.
- done  input  1  owner releases the grant; sampled only in GRANT.
- grant  output  N  one-hot grant, registered.
- grant_idx  output  IDX_W  binary index of the current owner, registered.
- grant_valid  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
- Reset mid-grant clears all outputs immediately, with no timeout pulse.
- State IDLE:
  - If any req bit is set, winner = first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - Next edge: grant_idx=winner, grant=1<<winner, grant_valid=1, counter=0, state=GRANT.
  - Grant latency: 1 cycle from req sampled to grant visible.
  - If req==0, stay in IDLE; done is ignored.
- State GRANT: release condition = done==1, OR req[grant_idx]==0, OR (MAX_HOLD!=0 and counter==MAX_HOLD-1).
  - On release, next edge: grant=0, grant_valid=0, ptr=(grant_idx+1) mod N (wraps 15->0 for N=16), state=IDLE.
  - Otherwise the counter increments by 1, saturating, never wrapping.
- timeout asserts for exactly the cycle grant drops, and only when the release is due solely to the counter.
  - If done or a req drop coincides with expiry, it is a normal release and timeout stays 0.
- Dead cycle: one mandatory IDLE cycle between consecutive grants. Grants are never back-to-back, and grant is never two-hot.
- Invariants:
  - grant==0 if and only if grant_valid==0.
  - When grant_valid==1, grant==(1<<grant_idx) exactly.
- Requests other than the owner's are ignored during GRANT. They are not latched; arbitration uses req as sampled in IDLE.
- The ptr update uses only the released owner's index. Requesters that never win do not move ptr.
- Fairness: with all N requesters asserted continuously, each is granted exactly once per N grants.

Test Plan:
- Reset then req=16'h0000 for 10 cycles -> grant=0, grant_valid=0, timeout=0 throughout; assert rst_n low mid-grant -> all outputs 0 the same cycle.
- From reset, req=16'h0014 -> one cycle later grant=16'h0004, grant_idx=2; pulse done -> grant=0 for one cycle, then grant=16'h0010, idx=4; release -> next win is idx 2 (wrap through 5..15, 0, 1).
- req=16'hFFFF held, done pulsed 2 cycles after each grant -> grant_idx sequence 0,1,...,15,0; each grant preceded by exactly one idle cycle.
- MAX_HOLD=4, req[7] held, done never -> grant=16'h0080 for 4 cycles, then grant drops with timeout=1 for one cycle, then regrant to 7 (only requester) after the idle cycle.
- MAX_HOLD=4, done asserted on the expiry cycle -> grant drops, timeout stays 0.
- Owner 3 drops req[3] while req[9] is high -> grant drops next edge, no timeout; after the idle cycle grant=16'h0200.
